// File: rtl/burst_drain_scheduler_if.sv
// Shared output channel of the burst drain scheduler: one beat per
// valid/ready handshake, tagged with its source requester and a last marker.
interface burst_drain_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int NBITS  = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [NBITS-1:0]  out_src;
  logic              out_last;

  // Scheduler side: produces beats, observes backpressure.
  modport master (
    output out_valid,
    output out_data,
    output out_src,
    output out_last,
    input  out_ready
  );

  // Downstream side: consumes beats, applies backpressure.
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_src,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/burst_drain_scheduler.sv
// Burst drain scheduler: round-robin selection among requesters whose FWFT
// FIFO holds data, then drains the winner in one burst that ends on the
// programmed beat count or when the FIFO is about to run dry.
module burst_drain_scheduler #(
  parameter int NREQS     = 4,
  parameter int NBITS     = $clog2(NREQS),
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int LBITS     = $clog2(MAX_BURST + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NREQS-1:0]          requests,
  input  logic [NREQS-1:0]          fifo_empty,
  input  logic [NREQS-1:0]          fifo_almost_empty,
  input  logic [NREQS*DATA_W-1:0]   fifo_data,
  output logic [NREQS-1:0]          fifo_pop,
  input  logic [LBITS-1:0]          cfg_burst_len,
  output logic                      busy,
  burst_drain_scheduler_if.master   out_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  last_served_q, last_served_d;
  logic [NBITS-1:0]  sel_q, sel_d;
  logic [LBITS-1:0]  burst_len_q, burst_len_d;
  logic [LBITS-1:0]  count_q, count_d;

  logic [NREQS-1:0]  eligible;
  logic              win_found;
  logic [NBITS-1:0]  win_idx;
  logic [LBITS-1:0]  len_clamped;
  logic              in_xfer;
  logic              last_beat;
  logic              handshake;
  logic [DATA_W-1:0] head_data;

  assign eligible = requests & ~fifo_empty;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    int               cand;
    logic [NBITS-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQS; i++) begin
      cand     = (int'(last_served_q) + i) % NREQS;
      cand_idx = NBITS'(cand);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Programmed burst length forced into 1..MAX_BURST.
  always_comb begin
    if (cfg_burst_len == '0) begin
      len_clamped = LBITS'(1);
    end else if (cfg_burst_len > LBITS'(MAX_BURST)) begin
      len_clamped = LBITS'(MAX_BURST);
    end else begin
      len_clamped = cfg_burst_len;
    end
  end

  // Output channel and pop strobe; data and last are passed through so a
  // pop lands in the same cycle as the beat it consumes.
  always_comb begin
    in_xfer   = (state_q == XFER);
    head_data = fifo_data[int'(sel_q)*DATA_W +: DATA_W];
    last_beat = (count_q == (burst_len_q - LBITS'(1))) || fifo_almost_empty[sel_q];
    handshake = in_xfer && out_if.out_ready;

    out_if.out_valid = in_xfer;
    out_if.out_data  = in_xfer ? head_data : '0;
    out_if.out_src   = in_xfer ? sel_q : '0;
    out_if.out_last  = in_xfer && last_beat;
    busy             = in_xfer;
    fifo_pop         = handshake ? (NREQS'(1) << sel_q) : '0;
  end

  // Next-state logic: arbitrate in IDLE, count beats in XFER, settle in GAP.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    sel_d         = sel_q;
    burst_len_d   = burst_len_q;
    count_d       = count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          sel_d       = win_idx;
          burst_len_d = len_clamped;
          count_d     = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (handshake) begin
          count_d = count_q + LBITS'(1);
          if (last_beat) begin
            last_served_d = sel_q;
            state_d       = GAP;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset points the round-robin so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_served_q <= NBITS'(NREQS - 1);
      sel_q         <= '0;
      burst_len_q   <= LBITS'(1);
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      sel_q         <= sel_d;
      burst_len_q   <= burst_len_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_burst_drain_scheduler.sv
// Bench for burst_drain_scheduler: FWFT FIFO environment, a transaction-level
// scheduling model, table vectors, hand-written corner sequences and
// randomized rounds.
module tb_burst_drain_scheduler;
  localparam int NREQS     = 4;
  localparam int NBITS     = 2;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int LBITS     = 4;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [NREQS-1:0]        requests;
  logic [NREQS-1:0]        fifo_empty;
  logic [NREQS-1:0]        fifo_almost_empty;
  logic [NREQS*DATA_W-1:0] fifo_data;
  logic [NREQS-1:0]        fifo_pop;
  logic [LBITS-1:0]        cfg_burst_len;
  logic                    busy;

  burst_drain_scheduler_if #(.DATA_W(DATA_W), .NBITS(NBITS)) bus ();

  burst_drain_scheduler #(
    .NREQS(NREQS), .NBITS(NBITS), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .LBITS(LBITS)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .requests          (requests),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data         (fifo_data),
    .fifo_pop          (fifo_pop),
    .cfg_burst_len     (cfg_burst_len),
    .busy              (busy),
    .out_if            (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct { int src; int beats; } burst_t;

  typedef struct packed {
    logic [NREQS-1:0]      reqs;
    logic [NREQS-1:0][7:0] depth;
    logic [3:0]            cfg;
    logic [2:0]            nb;
    logic [4:0][2:0]       src;
    logic [4:0][3:0]       beats;
    logic                  quiet;
  } vec_t;

  vec_t vecs [6];

  // FWFT FIFO environment as ring buffers
  logic [DATA_W-1:0] fmem [NREQS][256];
  int unsigned       f_rd [NREQS];
  int unsigned       f_wr [NREQS];

  // monitor state
  burst_t           bq[$];
  int               cur_src = 0;
  int               cur_beats = 0;
  int               idle_run = 2;
  logic             prev_valid = 1'b0;
  int               pop_total = 0;
  logic [NREQS-1:0] pend_pop = '0;

  function automatic int fsize(input int i);
    return int'(f_wr[i] - f_rd[i]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NREQS; i++) begin
      fifo_empty[i]        = (fsize(i) == 0);
      fifo_almost_empty[i] = (fsize(i) == 1);
      fifo_data[i*DATA_W +: DATA_W] = (fsize(i) > 0) ? fmem[i][f_rd[i] % 256] : '0;
    end
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      fmem[i][f_wr[i] % 256] = $urandom;
      f_wr[i]++;
    end
    refresh();
  endtask

  task automatic flush();
    for (int i = 0; i < NREQS; i++) f_rd[i] = f_wr[i];
    refresh();
  endtask

  // One clock: sample/monitor at negedge, apply pops at posedge, return at posedge+2.
  task automatic tick();
    int               s;
    logic [NREQS-1:0] exp_pop;
    @(negedge clock);
    if (!reset_n) begin
      cur_beats  = 0;
      pend_pop   = '0;
      idle_run   = 2;
      prev_valid = 1'b0;
    end else begin
      exp_pop = (bus.out_valid && bus.out_ready) ? (NREQS'(1) << bus.out_src) : '0;
      check("pop_strobe", fifo_pop, exp_pop);
      pend_pop = fifo_pop;
      if (bus.out_valid) begin
        if (!prev_valid) check("gap_cycles_ge2", idle_run >= 2, 1);
        idle_run = 0;
      end else if (idle_run < 100) begin
        idle_run++;
      end
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        s = int'(bus.out_src);
        check("pop_nonempty", fsize(s) > 0, 1);
        check("beat_data", bus.out_data, fmem[s][f_rd[s] % 256]);
        if (cur_beats == 0) cur_src = s;
        else check("src_stable", s, cur_src);
        cur_beats++;
        if (bus.out_last) begin
          check("beats_le_max", cur_beats <= MAX_BURST, 1);
          $display("burst src=%0d beats=%0d t=%0t", cur_src, cur_beats, $time);
          bq.push_back('{cur_src, cur_beats});
          cur_beats = 0;
        end
      end
    end
    @(posedge clock);
    for (int i = 0; i < NREQS; i++) begin
      if (pend_pop[i] && fsize(i) > 0) begin
        f_rd[i]++;
        pop_total++;
      end
    end
    #1 refresh();
    #1;
  endtask

  task automatic do_reset();
    requests      = '0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic settle_and_clear();
    requests = '0;
    repeat (12) tick();
    flush();
    bq.delete();
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int k;
    k = 0;
    while (bq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("burst_wait_budget", bq.size() >= n, 1);
  endtask

  function automatic burst_t take();
    burst_t b;
    if (bq.size() > 0) b = bq.pop_front();
    else b = '{-1, -1};
    return b;
  endfunction

  task automatic new_vec(input int v, input logic [NREQS-1:0] r, input int cfg, input bit q);
    vecs[v]       = '0;
    vecs[v].reqs  = r;
    vecs[v].cfg   = 4'(cfg);
    vecs[v].quiet = q;
  endtask

  task automatic add_exp(input int v, input int s, input int b);
    vecs[v].src[vecs[v].nb]   = 3'(s);
    vecs[v].beats[vecs[v].nb] = 4'(b);
    vecs[v].nb                = vecs[v].nb + 3'd1;
  endtask

  task automatic run_vec(input int vi);
    vec_t   v;
    burst_t b;
    v = vecs[vi];
    settle_and_clear();
    do_reset();
    for (int i = 0; i < NREQS; i++) load(i, int'(v.depth[i]));
    cfg_burst_len = v.cfg;
    requests      = v.reqs;
    wait_bursts(int'(v.nb), 400);
    for (int k = 0; k < int'(v.nb); k++) begin
      b = take();
      check($sformatf("vec%0d_burst%0d_src", vi, k), b.src, int'(v.src[k]));
      check($sformatf("vec%0d_burst%0d_beats", vi, k), b.beats, int'(v.beats[k]));
    end
    if (v.quiet) begin
      repeat (20) tick();
      check($sformatf("vec%0d_no_extra_burst", vi), bq.size(), 0);
      check($sformatf("vec%0d_idle_valid", vi), bus.out_valid, 0);
    end
  endtask

  initial begin
    burst_t           b;
    burst_t           eq[$];
    logic [DATA_W-1:0] held_d;
    logic [NBITS-1:0]  held_s;
    int               p0, k, mptr, clen, found, idx;
    int               msz [NREQS];
    logic [NREQS-1:0] rreq;

    for (int i = 0; i < NREQS; i++) begin
      f_rd[i] = 0;
      f_wr[i] = 0;
    end
    reset_n       = 1'b0;
    requests      = 4'b1111;
    cfg_burst_len = 4'd4;
    bus.out_ready = 1'b1;
    refresh();
    for (int i = 0; i < NREQS; i++) load(i, 10);

    // reset state with everything eligible
    tick();
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_pop", fifo_pop, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_out_data", bus.out_data, 0);

    // table vectors
    new_vec(0, 4'b1111, 4, 1'b0);
    for (int i = 0; i < NREQS; i++) vecs[0].depth[i] = 8'd10;
    add_exp(0, 0, 4); add_exp(0, 1, 4); add_exp(0, 2, 4); add_exp(0, 3, 4); add_exp(0, 0, 4);
    new_vec(1, 4'b0100, 8, 1'b1);
    vecs[1].depth[2] = 8'd3;
    add_exp(1, 2, 3);
    new_vec(2, 4'b0001, 0, 1'b1);
    vecs[2].depth[0] = 8'd2;
    add_exp(2, 0, 1); add_exp(2, 0, 1);
    new_vec(3, 4'b0001, 15, 1'b1);
    vecs[3].depth[0] = 8'd10;
    add_exp(3, 0, 8); add_exp(3, 0, 2);
    new_vec(4, 4'b1010, 8, 1'b1);
    vecs[4].depth[1] = 8'd2; vecs[4].depth[3] = 8'd2;
    add_exp(4, 1, 2); add_exp(4, 3, 2);
    new_vec(5, 4'b0110, 3, 1'b1);
    vecs[5].depth[0] = 8'd3; vecs[5].depth[1] = 8'd5; vecs[5].depth[2] = 8'd1;
    add_exp(5, 1, 3); add_exp(5, 2, 1); add_exp(5, 1, 2);
    reset_n = 1'b1;
    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // stall: ready 1,0,0,1 on src 1, 4-beat burst
    settle_and_clear();
    do_reset();
    load(1, 10);
    cfg_burst_len = 4'd4;
    requests      = 4'b0010;
    tick();
    check("stall_first_valid_latency", bus.out_valid, 1);
    check("stall_first_src", bus.out_src, 1);
    p0 = pop_total;
    tick();
    bus.out_ready = 1'b0;
    #1;
    held_d = bus.out_data;
    held_s = bus.out_src;
    check("stall_no_pop", fifo_pop, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("stall_hold_valid", bus.out_valid, 1);
      check("stall_hold_data", bus.out_data, held_d);
      check("stall_hold_src", bus.out_src, held_s);
      check("stall_hold_no_pop", fifo_pop, 0);
    end
    bus.out_ready = 1'b1;
    wait_bursts(1, 50);
    requests = '0;
    b = take();
    check("stall_burst_src", b.src, 1);
    check("stall_burst_beats", b.beats, 4);
    repeat (6) tick();
    check("stall_total_pops", pop_total - p0, 4);

    // fairness: pointer on 1, eligible {0,3} -> 3 then 0
    settle_and_clear();
    do_reset();
    load(1, 1);
    load(3, 2);
    cfg_burst_len = 4'd8;
    requests      = 4'b1011;
    tick();
    check("fair_first_src", bus.out_src, 1);
    load(0, 2);
    wait_bursts(3, 200);
    b = take(); check("fair_b0_src", b.src, 1); check("fair_b0_beats", b.beats, 1);
    b = take(); check("fair_b1_src", b.src, 3); check("fair_b1_beats", b.beats, 2);
    b = take(); check("fair_b2_src", b.src, 0); check("fair_b2_beats", b.beats, 2);

    // reset asserted on beat 2 of a burst on src 2
    settle_and_clear();
    do_reset();
    load(1, 2);
    load(2, 10);
    cfg_burst_len = 4'd4;
    requests      = 4'b0110;
    wait_bursts(1, 100);
    b = take(); check("rstmid_pre_src", b.src, 1); check("rstmid_pre_beats", b.beats, 2);
    k = 0;
    while (!(cur_beats == 1 && bus.out_valid && bus.out_src == 2) && k < 100) begin
      tick();
      k++;
    end
    check("rstmid_reach_beat2", k < 100, 1);
    reset_n = 1'b0;
    #1;
    check("rstmid_async_valid", bus.out_valid, 0);
    check("rstmid_async_busy", busy, 0);
    check("rstmid_async_pop", fifo_pop, 0);
    check("rstmid_async_last", bus.out_last, 0);
    load(0, 3);
    load(3, 3);
    requests = 4'b1111;
    tick();
    tick();
    check("rstmid_abandoned_depth", fsize(2), 9);
    reset_n = 1'b1;
    wait_bursts(1, 100);
    b = take(); check("rstmid_restart_src", b.src, 0); check("rstmid_restart_beats", b.beats, 3);

    // randomized rounds against the transaction-level model
    settle_and_clear();
    do_reset();
    mptr = NREQS - 1;
    for (int r = 0; r < 12; r++) begin
      settle_and_clear();
      rreq = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQS; i++) load(i, $urandom_range(0, 12));
      cfg_burst_len = 4'($urandom_range(0, 15));
      clen = (cfg_burst_len == 0) ? 1 :
             (int'(cfg_burst_len) > MAX_BURST) ? MAX_BURST : int'(cfg_burst_len);
      for (int i = 0; i < NREQS; i++) msz[i] = fsize(i);
      eq.delete();
      for (int guard = 0; guard < 200; guard++) begin
        found = -1;
        for (int j = 1; j <= NREQS; j++) begin
          idx = (mptr + j) % NREQS;
          if (found < 0 && rreq[idx] && msz[idx] > 0) found = idx;
        end
        if (found < 0) break;
        b = '{found, (msz[found] < clen) ? msz[found] : clen};
        eq.push_back(b);
        msz[found] -= b.beats;
        mptr = found;
      end
      requests = rreq;
      k = 0;
      while (bq.size() < eq.size() && k < 2000) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
        k++;
      end
      bus.out_ready = 1'b1;
      check($sformatf("rand%0d_burst_count_budget", r), bq.size() >= eq.size(), 1);
      for (int j = 0; j < eq.size(); j++) begin
        b = take();
        check($sformatf("rand%0d_b%0d_src", r, j), b.src, eq[j].src);
        check($sformatf("rand%0d_b%0d_beats", r, j), b.beats, eq[j].beats);
      end
      repeat (10) tick();
      check($sformatf("rand%0d_no_extra", r), bq.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
